// File: rtl/argmax_pkg.sv
// Shared types and helpers for the streaming argmax block.
// Latency: n/a (package only).
// Backpressure: n/a.
// Contents: FSM state enum, index-width helper, signed compare used by the
// lane tree and the running merge.
package argmax_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Scores of any configured width are sign-extended to this width before
  // comparison so one compare function serves every parameterisation.
  localparam int SCORE_MAX_W = 64;

  // $clog2 that never yields a zero-width vector.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic logic signed_gt(input logic signed [SCORE_MAX_W-1:0] a,
                                     input logic signed [SCORE_MAX_W-1:0] b);
    return a > b;
  endfunction

endpackage

// File: rtl/argmax_lane_tree.sv
// Combinational reduction of one beat of LANES signed scores to its winner.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller qualifies the result with its handshake.
// Ports: lanes (packed scores, lane k at [k*NUM_SIZE +: NUM_SIZE]) ->
//   max1/idx1 (winner, lane-local index); with ARGMAX_RUNNER_UP_EN also
//   max2/idx2/vld2 (runner-up, vld2=0 when LANES==1).
// Ties always resolve to the lower lane.
module argmax_lane_tree
  import argmax_pkg::*;
#(
  parameter int NUM_SIZE = 26,
  parameter int LANES    = 2,
  parameter int LIDX_W   = 1
) (
  input  logic [LANES*NUM_SIZE-1:0] lanes,
  output logic [NUM_SIZE-1:0]       max1,
  output logic [LIDX_W-1:0]         idx1
`ifdef ARGMAX_RUNNER_UP_EN
  ,
  output logic [NUM_SIZE-1:0]       max2,
  output logic [LIDX_W-1:0]         idx2,
  output logic                      vld2
`endif
);

  function automatic logic [SCORE_MAX_W-1:0] sx(input logic [NUM_SIZE-1:0] v);
    return {{(SCORE_MAX_W-NUM_SIZE){v[NUM_SIZE-1]}}, v};
  endfunction

  logic [NUM_SIZE-1:0] s;

  // Lanes are scanned in ascending order and only a strictly greater score
  // displaces an incumbent, which gives lowest-lane-wins on ties.
  always_comb begin
    s    = '0;
    max1 = lanes[0 +: NUM_SIZE];
    idx1 = '0;
`ifdef ARGMAX_RUNNER_UP_EN
    max2 = '0;
    idx2 = '0;
    vld2 = 1'b0;
`endif
    for (int k = 1; k < LANES; k++) begin
      s = lanes[k*NUM_SIZE +: NUM_SIZE];
      if (signed_gt(sx(s), sx(max1))) begin
`ifdef ARGMAX_RUNNER_UP_EN
        max2 = max1;
        idx2 = idx1;
        vld2 = 1'b1;
`endif
        max1 = s;
        idx1 = LIDX_W'(k);
      end
`ifdef ARGMAX_RUNNER_UP_EN
      else if (!vld2 || signed_gt(sx(s), sx(max2))) begin
        max2 = s;
        idx2 = LIDX_W'(k);
        vld2 = 1'b1;
      end
`endif
    end
  end

endmodule

// File: rtl/argmax_stream.sv
// Streaming argmax over NUM_CLASSES signed scores received LANES per beat.
// Latency: out_valid rises the cycle after the final beat is accepted.
// Backpressure: in_ready=0 while a result waits in DONE; result held until out_ready.
// Ports: clk, GlobalReset (async, active-high); in_valid/in_ready/in_data
//   (score index = beat*LANES + lane); out_valid/out_ready/out_index/out_max.
// Optional: define ARGMAX_RUNNER_UP_EN to add out_index2/out_max2 (runner-up).
module argmax_stream
  import argmax_pkg::*;
#(
  parameter int  NUM_SIZE    = 26,
  parameter int  NUM_CLASSES = 10,
  parameter int  LANES       = 2,
  localparam int IDX_W       = idx_width(NUM_CLASSES)
) (
  input  logic                      clk,
  input  logic                      GlobalReset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*NUM_SIZE-1:0] in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [IDX_W-1:0]          out_index,
  output logic [NUM_SIZE-1:0]       out_max
`ifdef ARGMAX_RUNNER_UP_EN
  ,
  output logic [IDX_W-1:0]          out_index2,
  output logic [NUM_SIZE-1:0]       out_max2
`endif
);

  localparam int BEATS  = NUM_CLASSES / LANES;
  localparam int LIDX_W = idx_width(LANES);
  localparam int CNT_W  = idx_width(BEATS);

  function automatic logic [SCORE_MAX_W-1:0] sx(input logic [NUM_SIZE-1:0] v);
    return {{(SCORE_MAX_W-NUM_SIZE){v[NUM_SIZE-1]}}, v};
  endfunction

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NUM_SIZE-1:0] run_max_q, run_max_d;
  logic [IDX_W-1:0]    run_idx_q, run_idx_d;
  logic [IDX_W-1:0]    out_index_q, out_index_d;
  logic [NUM_SIZE-1:0] out_max_q, out_max_d;

  logic [NUM_SIZE-1:0] l_max1;
  logic [LIDX_W-1:0]   l_idx1;
  logic [IDX_W-1:0]    lane_base, lane_idx1;
  logic [NUM_SIZE-1:0] m_max;
  logic [IDX_W-1:0]    m_idx;
  logic                first_beat, last_beat, accept;

`ifdef ARGMAX_RUNNER_UP_EN
  logic [NUM_SIZE-1:0] run_max2_q, run_max2_d;
  logic [IDX_W-1:0]    run_idx2_q, run_idx2_d;
  logic                run_vld2_q, run_vld2_d;
  logic [IDX_W-1:0]    out_index2_q, out_index2_d;
  logic [NUM_SIZE-1:0] out_max2_q, out_max2_d;
  logic [NUM_SIZE-1:0] l_max2;
  logic [LIDX_W-1:0]   l_idx2;
  logic                l_vld2;
  logic [IDX_W-1:0]    lane_idx2;
  logic [NUM_SIZE-1:0] m_max2;
  logic [IDX_W-1:0]    m_idx2;
`endif

  argmax_lane_tree #(
    .NUM_SIZE (NUM_SIZE),
    .LANES    (LANES),
    .LIDX_W   (LIDX_W)
  ) u_lane_tree (
    .lanes (in_data),
    .max1  (l_max1),
    .idx1  (l_idx1)
`ifdef ARGMAX_RUNNER_UP_EN
    ,
    .max2  (l_max2),
    .idx2  (l_idx2),
    .vld2  (l_vld2)
`endif
  );

  assign in_ready  = ~GlobalReset & (state_q != DONE);
  assign out_valid = (state_q == DONE);
  assign out_index = out_index_q;
  assign out_max   = out_max_q;
`ifdef ARGMAX_RUNNER_UP_EN
  assign out_index2 = out_index2_q;
  assign out_max2   = out_max2_q;
`endif

  assign accept     = in_valid & in_ready;
  assign first_beat = (state_q == IDLE);
  assign last_beat  = (cnt_q == CNT_W'(BEATS - 1));
  assign lane_base  = IDX_W'(int'(cnt_q) * LANES);
  assign lane_idx1  = lane_base + IDX_W'(l_idx1);
`ifdef ARGMAX_RUNNER_UP_EN
  assign lane_idx2  = lane_base + IDX_W'(l_idx2);
`endif

  // Merge the beat winner into the running result. Every running candidate
  // carries a lower index than any candidate of the current beat, so on an
  // equal score the running entry is kept.
  always_comb begin
    m_max = l_max1;
    m_idx = lane_idx1;
    if (!first_beat && !signed_gt(sx(l_max1), sx(run_max_q))) begin
      m_max = run_max_q;
      m_idx = run_idx_q;
    end
`ifdef ARGMAX_RUNNER_UP_EN
    // Runner-up comes from the side that lost the top slot (its best) or the
    // side that won it (its second); earlier-index candidate wins ties.
    m_max2 = l_max2;
    m_idx2 = lane_idx2;
    if (first_beat || signed_gt(sx(l_max1), sx(run_max_q))) begin
      if (!first_beat &&
          !(l_vld2 && signed_gt(sx(l_max2), sx(run_max_q)))) begin
        m_max2 = run_max_q;
        m_idx2 = run_idx_q;
      end
    end else begin
      if (run_vld2_q && !signed_gt(sx(l_max1), sx(run_max2_q))) begin
        m_max2 = run_max2_q;
        m_idx2 = run_idx2_q;
      end else begin
        m_max2 = l_max1;
        m_idx2 = lane_idx1;
      end
    end
`endif
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    run_max_d   = run_max_q;
    run_idx_d   = run_idx_q;
    out_index_d = out_index_q;
    out_max_d   = out_max_q;
`ifdef ARGMAX_RUNNER_UP_EN
    run_max2_d   = run_max2_q;
    run_idx2_d   = run_idx2_q;
    run_vld2_d   = run_vld2_q;
    out_index2_d = out_index2_q;
    out_max2_d   = out_max2_q;
`endif
    case (state_q)
      IDLE, ACCUM: begin
        if (accept) begin
          run_max_d = m_max;
          run_idx_d = m_idx;
`ifdef ARGMAX_RUNNER_UP_EN
          run_max2_d = m_max2;
          run_idx2_d = m_idx2;
          run_vld2_d = !first_beat || l_vld2;
`endif
          if (last_beat) begin
            state_d     = DONE;
            cnt_d       = '0;
            out_index_d = m_idx;
            out_max_d   = m_max;
`ifdef ARGMAX_RUNNER_UP_EN
            out_index2_d = m_idx2;
            out_max2_d   = m_max2;
`endif
          end else begin
            state_d = ACCUM;
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge GlobalReset) begin
    if (GlobalReset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      run_max_q   <= '0;
      run_idx_q   <= '0;
      out_index_q <= '1;
      out_max_q   <= '0;
`ifdef ARGMAX_RUNNER_UP_EN
      run_max2_q   <= '0;
      run_idx2_q   <= '0;
      run_vld2_q   <= 1'b0;
      out_index2_q <= '1;
      out_max2_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      run_max_q   <= run_max_d;
      run_idx_q   <= run_idx_d;
      out_index_q <= out_index_d;
      out_max_q   <= out_max_d;
`ifdef ARGMAX_RUNNER_UP_EN
      run_max2_q   <= run_max2_d;
      run_idx2_q   <= run_idx2_d;
      run_vld2_q   <= run_vld2_d;
      out_index2_q <= out_index2_d;
      out_max2_q   <= out_max2_d;
`endif
    end
  end

endmodule

// File: tb/tb_argmax_stream.sv
// Self-checking bench for argmax_stream with a reference argmax model.
// Latency: n/a (testbench).
// Backpressure: exercises stalls in DONE and input bubbles.
module tb_argmax_stream;

  localparam int NS    = 26;
  localparam int NC    = 10;
  localparam int LN    = 2;
  localparam int BEATS = NC / LN;
  localparam int IW    = $clog2(NC);
  localparam int ALL1  = (1 << IW) - 1;
  localparam int SMIN  = -(1 << (NS - 1));
  localparam int SMAX  = (1 << (NS - 1)) - 1;

  logic             clk = 1'b0;
  logic             GlobalReset;
  logic             in_valid;
  logic             in_ready;
  logic [LN*NS-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [IW-1:0]    out_index;
  logic [NS-1:0]    out_max;
`ifdef ARGMAX_RUNNER_UP_EN
  logic [IW-1:0]    out_index2;
  logic [NS-1:0]    out_max2;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  argmax_stream #(
    .NUM_SIZE    (NS),
    .NUM_CLASSES (NC),
    .LANES       (LN)
  ) dut (
    .clk         (clk),
    .GlobalReset (GlobalReset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_index   (out_index),
    .out_max     (out_max)
`ifdef ARGMAX_RUNNER_UP_EN
    ,
    .out_index2  (out_index2),
    .out_max2    (out_max2)
`endif
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: first index holding the largest value; runner-up is the
  // largest of the remaining entries, again first index on ties.
  function automatic void ref_argmax(input int v[NC], output int i1, output int m1,
                                     output int i2, output int m2);
    i1 = 0;
    for (int i = 1; i < NC; i++) if (v[i] > v[i1]) i1 = i;
    m1 = v[i1];
    i2 = -1;
    for (int i = 0; i < NC; i++)
      if (i != i1 && (i2 < 0 || v[i] > v[i2])) i2 = i;
    m2 = v[i2];
  endfunction

  function automatic int rand_score(input int mode);
    int r;
    case (mode)
      0:       r = int'($urandom) >>> (32 - NS);
      1:       r = int'($urandom_range(0, 6)) - 3;
      default: begin
        case ($urandom_range(0, 2))
          0:       r = SMIN;
          1:       r = SMAX;
          default: r = int'($urandom_range(0, 4)) - 2;
        endcase
      end
    endcase
    return r;
  endfunction

  // Called just after a falling edge; returns just after the falling edge
  // that follows acceptance of the last beat sent.
  task automatic send_beats(input int v[NC], input int nbeats, input bit bubbles);
    for (int b = 0; b < nbeats; b++) begin
      if (bubbles) repeat ($urandom_range(0, 2)) @(negedge clk);
      for (int k = 0; k < LN; k++) in_data[k*NS +: NS] = NS'(v[b*LN + k]);
      in_valid = 1'b1;
      check("beat_in_ready", int'(in_ready), 1);
      check("beat_out_valid_low", int'(out_valid), 0);
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic check_result(input string tag, input int v[NC]);
    int i1, m1, i2, m2;
    ref_argmax(v, i1, m1, i2, m2);
    check({tag, "_index"}, int'(out_index), i1);
    check({tag, "_max"}, int'($signed(out_max)), m1);
`ifdef ARGMAX_RUNNER_UP_EN
    check({tag, "_index2"}, int'(out_index2), i2);
    check({tag, "_max2"}, int'($signed(out_max2)), m2);
`endif
  endtask

  task automatic run_vector(input string tag, input int v[NC], input bit bubbles,
                            input int stall);
    send_beats(v, BEATS, bubbles);
    check({tag, "_latency_valid"}, int'(out_valid), 1);
    check_result(tag, v);
    repeat (stall) begin
      @(negedge clk);
      check({tag, "_hold_valid"}, int'(out_valid), 1);
    end
    if (stall > 0) check_result({tag, "_held"}, v);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_post_hs_valid"}, int'(out_valid), 0);
    check({tag, "_post_hs_ready"}, int'(in_ready), 1);
    check_result({tag, "_post_hs"}, v);
  endtask

  initial begin
    int v[NC];
    int i1, m1, i2, m2;

    GlobalReset = 1'b1;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    in_data     = '0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_index", int'(out_index), ALL1);
    check("rst_out_max", int'($signed(out_max)), 0);
    GlobalReset = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", int'(in_ready), 1);
    check("post_rst_out_valid", int'(out_valid), 0);

    for (int i = 0; i < NC; i++) v[i] = i;
    run_vector("ascending", v, 1'b0, 0);

    for (int i = 0; i < NC; i++) v[i] = -100;
    v[3] = -5;
    run_vector("neg_peak", v, 1'b0, 0);

    for (int i = 0; i < NC; i++) v[i] = 7;
    run_vector("all_equal", v, 1'b0, 0);

    for (int i = 0; i < NC; i++) v[i] = i - 3;
    v[4] = 12;
    v[6] = 12;
    run_vector("tie_4_6", v, 1'b1, 0);

    for (int i = 0; i < NC; i++) v[i] = SMIN + 1;
    v[0] = SMIN;
    run_vector("most_neg", v, 1'b0, 0);

    for (int i = 0; i < NC; i++) v[i] = SMIN;
    run_vector("all_most_neg", v, 1'b0, 0);

    v = '{3, 9, 9, 1, 4, -1, 0, 5, 2, -2};
    run_vector("runner_up", v, 1'b0, 0);

    // Stall in DONE with in_valid asserted: nothing may be consumed.
    for (int i = 0; i < NC; i++) v[i] = rand_score(0);
    send_beats(v, BEATS, 1'b0);
    ref_argmax(v, i1, m1, i2, m2);
    check("stall_latency_valid", int'(out_valid), 1);
    in_valid = 1'b1;
    for (int k = 0; k < LN; k++) in_data[k*NS +: NS] = NS'(SMAX);
    for (int c = 0; c < 5; c++) begin
      check("stall_out_valid", int'(out_valid), 1);
      check("stall_in_ready", int'(in_ready), 0);
      check("stall_index", int'(out_index), i1);
      check("stall_max", int'($signed(out_max)), m1);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("stall_post_hs_valid", int'(out_valid), 0);
    for (int i = 0; i < NC; i++) v[i] = NC - i;
    run_vector("after_stall", v, 1'b0, 0);

    // Reset partway through a vector.
    for (int i = 0; i < NC; i++) v[i] = 5000 - i;
    send_beats(v, 3, 1'b0);
    GlobalReset = 1'b1;
    #1;
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_out_index", int'(out_index), ALL1);
    check("midrst_out_max", int'($signed(out_max)), 0);
    check("midrst_in_ready", int'(in_ready), 0);
    @(negedge clk);
    GlobalReset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < NC; i++) v[i] = i * 3 - 10;
    v[1] = 40;
    run_vector("after_midrst", v, 1'b0, 0);

    for (int n = 0; n < 40; n++) begin
      int mode;
      mode = $urandom_range(0, 2);
      for (int i = 0; i < NC; i++) v[i] = rand_score(mode);
      run_vector("random", v, 1'b1, $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
